pair_dist_sequencer: RTL
========================

// Module: pair_dist_sequencer
// PURPOSE
//  Hardware sequencer for program-2 min/max work: finds min/max |a-b| over all pairs of N signed 16-bit values.
//  Values are big-endian byte pairs in data memory: value i = {mem[BASE+2i], mem[BASE+2i+1]}.
//  Results go back to data memory: Min -> mem[MIN_ADDR:+1], Max -> mem[MAX_ADDR:+1], both big-endian.
//  Sits beside top_level as a memory-port master, muxed onto the dm port while busy=1.
// PARAMETERS
//  N_VALS     32  number of 16-bit values (2..32)
//  BASE_ADDR  0   byte address of value 0
//  MIN_ADDR   66  byte address of Min high byte
//  MAX_ADDR   68  byte address of Max high byte
// PORTS
//  clk          in   1  clock, all state on rising edge
//  reset        in   1  synchronous, active-low reset
//  start        in   1  level request; sampled in IDLE only
//  done         out  1  acknowledge; high in DONE state
//  busy         out  1  high in LOAD/SCAN/WRITE; owns the memory port
//  mem_addr     out  8  byte address to data memory
//  mem_rd_data  in   8  read data; combinational (same-cycle) read
//  mem_wr_en    out  1  byte write strobe, written on rising edge
//  mem_wr_data  out  8  write byte
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
//    Counters, min (0xFFFF) and max (0x0000) are also cleared.
//  Reset mid-operation aborts at once. No further writes occur. Partial results are never written.
//  State machine (Moore outputs):
//   IDLE : start==1 at edge -> LOAD with byte ctr c=0, min=0xFFFF, max=0.
//   LOAD : mem_addr=BASE_ADDR+c; mem_rd_data is captured into cache byte c at the edge.
//          Even c = high byte, odd c = low byte. After c=2N-1 -> SCAN with j=0, k=1.
//   SCAN : one pair per cycle. diff = 17-bit signed cache[j]-cache[k]; dist = |diff| (0..65535, fits 16 b).
//          If dist<min: min<=dist. If dist>max: max<=dist. Compares are strict, so the earliest pair wins ties.
//          Order: k++; when k==N-1 then j++, k=j+1. After pair (N-2, N-1) -> WRITE.
//   WRITE: 4 cycles, mem_wr_en=1. Writes in order: MIN_ADDR<=min[15:8], MIN_ADDR+1<=min[7:0],
//          MAX_ADDR<=max[15:8], MAX_ADDR+1<=max[7:0]. Then -> DONE.
//   DONE : done=1, busy=0. Stays here while start==1. start==0 at edge -> IDLE, so done drops next cycle.
//  Latency: done rises 2N + N(N-1)/2 + 4 cycles after the edge that samples start (N=32: 564).
//  start is ignored outside IDLE/DONE; re-asserting it while busy has no effect.
//  A new run requires start low (DONE->IDLE), then high again.
//  mem_wr_en is never 1 outside WRITE. mem_addr=0 in IDLE/DONE.
// CONFIGURATION
//  PAIR_DIST_IDX_EN defined:
//    Adds outputs min_j, min_k, max_j, max_k (5 b each). They capture j/k whenever min/max update.
//    Reset value 0. Valid while done=1.
//  Not defined: these ports and the index registers are absent. All else is identical.
// TESTING
//  1 value i = 3*i, i=0..31 -> mem[66:67]=0x0003, mem[68:69]=0x005D.
//    done rises exactly 564 cycles after start is sampled.
//  2 all values 0x1234 -> Min=0x0000, Max=0x0000. With IDX_EN: min=(0,1), max=(0,1) since max never updates.
//  3 v0=-32768, v31=32767, others 0 -> Max=0xFFFF, Min=0x0000.
//    With IDX_EN: max=(0,31), min=(1,2).
//  4 reset low for 1 cycle during SCAN (cycle 200) -> busy=0, done=0, mem[66:69] keep preloads FFFF/0000.
//    A following start yields correct results.
//  5 start held high after done -> done stays 1, no memory activity.
//    Drop start -> done=0 next cycle; re-raise start -> full rerun, same results.
//  6 N_VALS=2, values 5 and -5 -> Min=Max=0x000A, done 9 cycles after start.

Source files
------------

// File: rtl/pair_dist_sequencer.sv
// Memory-port sequencer that finds the min and max |a-b| over all pairs of N signed 16-bit values.
// Optional build macro PAIR_DIST_IDX_EN adds pair-index outputs for the min and max results.
module pair_dist_sequencer #(
   parameter int N_VALS    = 32,
   parameter int BASE_ADDR = 0,
   parameter int MIN_ADDR  = 66,
   parameter int MAX_ADDR  = 68
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic       busy,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data
`ifdef PAIR_DIST_IDX_EN
   ,
   output logic [4:0] min_j,
   output logic [4:0] min_k,
   output logic [4:0] max_j,
   output logic [4:0] max_k
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

   localparam logic [7:0] BASE_A = 8'(BASE_ADDR);
   localparam logic [7:0] MIN_A  = 8'(MIN_ADDR);
   localparam logic [7:0] MAX_A  = 8'(MAX_ADDR);
   localparam logic [5:0] LAST_C = 6'(2 * N_VALS - 1);
   localparam logic [4:0] LAST_K = 5'(N_VALS - 1);
   localparam logic [4:0] LAST_J = 5'(N_VALS - 2);

   state_t      state_r, state_s;
   logic [5:0]  c_r, c_s;
   logic [4:0]  j_r, j_s, k_r, k_s;
   logic [1:0]  w_r, w_s;
   logic [15:0] min_r, min_s, max_r, max_s;
   logic [7:0]  addr_s, wdata_s;
   logic        wr_en_s, done_s, busy_s;
   logic [15:0] cache_r [32];
   logic [16:0] diff_s;
   logic [15:0] dist_s;
`ifdef PAIR_DIST_IDX_EN
   logic [4:0]  min_j_s, min_k_s, max_j_s, max_k_s;
`endif

   // Sign-extend to 17 bits so |a-b| up to 65535 is exact
   always_comb begin
      diff_s = {cache_r[j_r][15], cache_r[j_r]} - {cache_r[k_r][15], cache_r[k_r]};
      if (diff_s[16]) begin
         dist_s = 16'(17'd0 - diff_s);
      end else begin
         dist_s = diff_s[15:0];
      end
   end

   // Next-state and next-output decode; outputs are registered one step ahead
   always_comb begin
      state_s = state_r;
      c_s     = c_r;
      j_s     = j_r;
      k_s     = k_r;
      w_s     = w_r;
      min_s   = min_r;
      max_s   = max_r;
      addr_s  = 8'h00;
      wdata_s = 8'h00;
      wr_en_s = 1'b0;
      done_s  = 1'b0;
      busy_s  = 1'b0;
`ifdef PAIR_DIST_IDX_EN
      min_j_s = min_j;
      min_k_s = min_k;
      max_j_s = max_j;
      max_k_s = max_k;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = LOAD;
               c_s     = 6'd0;
               min_s   = 16'hFFFF;
               max_s   = 16'h0000;
               busy_s  = 1'b1;
               addr_s  = BASE_A;
`ifdef PAIR_DIST_IDX_EN
               min_j_s = 5'd0;
               min_k_s = 5'd1;
               max_j_s = 5'd0;
               max_k_s = 5'd1;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            busy_s = 1'b1;
            if (c_r == LAST_C) begin
               state_s = SCAN;
               j_s     = 5'd0;
               k_s     = 5'd1;
            end else begin
               c_s    = c_r + 6'd1;
               addr_s = BASE_A + {2'b00, c_s};
            end
         end
         SCAN: begin
            busy_s = 1'b1;
            if (dist_s < min_r) begin
               min_s = dist_s;
`ifdef PAIR_DIST_IDX_EN
               min_j_s = j_r;
               min_k_s = k_r;
`endif
            end else begin
               min_s = min_r;
            end
            if (dist_s > max_r) begin
               max_s = dist_s;
`ifdef PAIR_DIST_IDX_EN
               max_j_s = j_r;
               max_k_s = k_r;
`endif
            end else begin
               max_s = max_r;
            end
            if (k_r == LAST_K) begin
               if (j_r == LAST_J) begin
                  // Last pair: the first write byte must already include its update
                  state_s = WRITE;
                  w_s     = 2'd0;
                  wr_en_s = 1'b1;
                  addr_s  = MIN_A;
                  wdata_s = min_s[15:8];
               end else begin
                  j_s = j_r + 5'd1;
                  k_s = j_r + 5'd2;
               end
            end else begin
               k_s = k_r + 5'd1;
            end
         end
         WRITE: begin
            if (w_r == 2'd3) begin
               state_s = DONE;
               done_s  = 1'b1;
            end else begin
               busy_s  = 1'b1;
               w_s     = w_r + 2'd1;
               wr_en_s = 1'b1;
               case (w_s)
                  2'd1:    begin addr_s = MIN_A + 8'd1; wdata_s = min_r[7:0];  end
                  2'd2:    begin addr_s = MAX_A;        wdata_s = max_r[15:8]; end
                  default: begin addr_s = MAX_A + 8'd1; wdata_s = max_r[7:0];  end
               endcase
            end
         end
         DONE: begin
            if (start) begin
               done_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, counters, results and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         c_r         <= 6'd0;
         j_r         <= 5'd0;
         k_r         <= 5'd0;
         w_r         <= 2'd0;
         min_r       <= 16'hFFFF;
         max_r       <= 16'h0000;
         done        <= 1'b0;
         busy        <= 1'b0;
         mem_addr    <= 8'h00;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= 8'h00;
`ifdef PAIR_DIST_IDX_EN
         min_j       <= 5'd0;
         min_k       <= 5'd0;
         max_j       <= 5'd0;
         max_k       <= 5'd0;
`endif
      end else begin
         state_r     <= state_s;
         c_r         <= c_s;
         j_r         <= j_s;
         k_r         <= k_s;
         w_r         <= w_s;
         min_r       <= min_s;
         max_r       <= max_s;
         done        <= done_s;
         busy        <= busy_s;
         mem_addr    <= addr_s;
         mem_wr_en   <= wr_en_s;
         mem_wr_data <= wdata_s;
`ifdef PAIR_DIST_IDX_EN
         min_j       <= min_j_s;
         min_k       <= min_k_s;
         max_j       <= max_j_s;
         max_k       <= max_k_s;
`endif
      end
   end

   // Even byte counter fills the high byte, odd fills the low byte
   always_ff @(posedge clk) begin
      if (reset && (state_r == LOAD)) begin
         if (c_r[0]) begin
            cache_r[c_r[5:1]][7:0] <= mem_rd_data;
         end else begin
            cache_r[c_r[5:1]][15:8] <= mem_rd_data;
         end
      end
   end

endmodule
